dense_biases_loader: RTL and testbench

- Sequences loading of the 10 dense-layer biases (40 bytes, little-endian, 32-bit words) from the byte stream into the dense biases RAM.
- Reads all 10 words back and produces a 32-bit additive checksum.
- Owns the RAM read port: inference reads are locked out until the biases are loaded and verified.
- Sits between the UART byte receiver, the bias RAM and the dense-layer engine.

---
 rtl/dense_biases_loader_if.sv | 56 +++++
 rtl/dense_biases_loader.sv | 160 ++++++++++++++++
 tb/tb_dense_biases_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_biases_loader_if.sv
// Bus bundle for the dense-layer bias loader: byte stream in, bias RAM write/read
// ports, and the inference read path and status seen by the dense engine.
interface dense_biases_loader_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [31:0]       ram_wr_data;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [31:0]       ram_rd_data;
    logic [ADDR_W-1:0] inf_rd_addr;
    logic [31:0]       inf_rd_data;
    logic              biases_ready;
    logic [31:0]       checksum;
    logic              load_err;

    // Loader side.
    modport slave (
        input  start,
        input  byte_valid,
        input  byte_data,
        input  ram_rd_data,
        input  inf_rd_addr,
        output byte_ready,
        output ram_wr_en,
        output ram_wr_addr,
        output ram_wr_data,
        output ram_rd_addr,
        output inf_rd_data,
        output biases_ready,
        output checksum,
        output load_err
    );

    // Environment side: byte source, RAM and dense engine.
    modport master (
        output start,
        output byte_valid,
        output byte_data,
        output ram_rd_data,
        output inf_rd_addr,
        input  byte_ready,
        input  ram_wr_en,
        input  ram_wr_addr,
        input  ram_wr_data,
        input  ram_rd_addr,
        input  inf_rd_data,
        input  biases_ready,
        input  checksum,
        input  load_err
    );
endinterface

// File: rtl/dense_biases_loader.sv
// Loads NUM_WORDS little-endian 32-bit bias words from a byte stream into the
// bias RAM, reads them back into an additive checksum, and gates the dense
// engine's read path until the load has been verified.
module dense_biases_loader #(
    parameter int unsigned NUM_WORDS = 10,
    parameter int unsigned ADDR_W    = 4
) (
    input logic                  clk,
    input logic                  rst,
    dense_biases_loader_if.slave bus_io
);

    // One extra bit so the word counter can hold NUM_WORDS even when it equals 2^ADDR_W.
    localparam int unsigned CntW = ADDR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StVerify,
        StReady
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [CntW-1:0]   word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [23:0]       shift_q, shift_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [31:0]       checksum_q, checksum_d;
    logic              load_err_q, load_err_d;

    logic              words_done;
    logic              byte_ready;

    // word_idx reaches NUM_WORDS in the last write-pulse cycle, which closes the byte window.
    assign words_done = (word_idx_q == CntW'(NUM_WORDS));
    assign byte_ready = (state_q == StLoad) && !words_done;

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            rd_idx_q   <= '0;
            shift_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            checksum_q <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            rd_idx_q   <= rd_idx_d;
            shift_q    <= shift_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            checksum_q <= checksum_d;
            load_err_q <= load_err_d;
        end
    end

    // Next-state logic: start overrides everything, then per-state sequencing.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        rd_idx_d   = rd_idx_q;
        shift_d    = shift_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        checksum_d = checksum_q;
        load_err_d = load_err_q;

        if (bus_io.start) begin
            // A byte coincident with start is dropped silently.
            state_d    = StLoad;
            byte_cnt_d = '0;
            word_idx_d = '0;
            rd_idx_d   = '0;
            shift_d    = '0;
            checksum_d = '0;
            load_err_d = 1'b0;
        end else begin
            if (bus_io.byte_valid && !byte_ready) begin
                load_err_d = 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                end

                StLoad: begin
                    if (words_done) begin
                        state_d  = StVerify;
                        rd_idx_d = '0;
                    end else if (bus_io.byte_valid) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        unique case (byte_cnt_q)
                            2'd0: shift_d[7:0]   = bus_io.byte_data;
                            2'd1: shift_d[15:8]  = bus_io.byte_data;
                            2'd2: shift_d[23:16] = bus_io.byte_data;
                            2'd3: begin
                                wr_en_d    = 1'b1;
                                wr_addr_d  = word_idx_q[ADDR_W-1:0];
                                wr_data_d  = {bus_io.byte_data, shift_q};
                                word_idx_d = word_idx_q + 1'b1;
                            end
                        endcase
                    end
                end

                StVerify: begin
                    checksum_d = checksum_q + bus_io.ram_rd_data;
                    if (rd_idx_q == ADDR_W'(NUM_WORDS - 1)) begin
                        state_d  = StReady;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end

                StReady: begin
                end

                default: state_d = StIdle;
            endcase
        end
    end

    // RAM read-port ownership: verify sweep, then the dense engine once ready.
    always_comb begin
        bus_io.ram_rd_addr = '0;
        bus_io.inf_rd_data = '0;
        case (state_q)
            StVerify: bus_io.ram_rd_addr = rd_idx_q;
            StReady: begin
                bus_io.ram_rd_addr = bus_io.inf_rd_addr;
                bus_io.inf_rd_data = bus_io.ram_rd_data;
            end
            default: begin
            end
        endcase
    end

    assign bus_io.byte_ready   = byte_ready;
    assign bus_io.ram_wr_en    = wr_en_q;
    assign bus_io.ram_wr_addr  = wr_addr_q;
    assign bus_io.ram_wr_data  = wr_data_q;
    assign bus_io.biases_ready = (state_q == StReady);
    assign bus_io.checksum     = checksum_q;
    assign bus_io.load_err     = load_err_q;

endmodule

// File: tb/tb_dense_biases_loader.sv
// Bench for dense_biases_loader: directed byte streams, a behavioural bias RAM,
// and a scoreboard whose monitor checks every RAM write and each checksum.
module tb_dense_biases_loader;

    logic clk;
    logic rst;

    int total;
    int bad;

    logic [3:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_ck_q[$];

    logic [31:0] mem [16];

    dense_biases_loader_if #(.ADDR_W(4)) bus ();

    dense_biases_loader #(
        .NUM_WORDS(10),
        .ADDR_W   (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bias RAM: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (bus.ram_wr_en === 1'b1) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    end
    assign bus.ram_rd_data = mem[bus.ram_rd_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, bus.ram_wr_en}, 32'd0);
        chk({tag, "_wr_addr"}, {28'd0, bus.ram_wr_addr}, 32'd0);
        chk({tag, "_wr_data"}, bus.ram_wr_data, 32'd0);
        chk({tag, "_biases_ready"}, {31'd0, bus.biases_ready}, 32'd0);
        chk({tag, "_checksum"}, bus.checksum, 32'd0);
        chk({tag, "_load_err"}, {31'd0, bus.load_err}, 32'd0);
        chk({tag, "_inf_rd_data"}, bus.inf_rd_data, 32'd0);
        chk({tag, "_rd_addr"}, {28'd0, bus.ram_rd_addr}, 32'd0);
    endtask

    // Streams n bytes (base, base+1, ... or constant base) and queues the expected words.
    // Returns at the cycle after the last byte is accepted.
    task automatic send_bytes(input int n, input logic [7:0] base, input bit incr,
                              input bit gapped);
        logic [31:0] w;
        logic [7:0]  b;
        w = '0;
        for (int i = 0; i < n; i++) begin
            b = incr ? base + 8'(i) : base;
            w[8*(i%4) +: 8] = b;
            if (i % 4 == 3) begin
                exp_addr_q.push_back(4'(i / 4));
                exp_data_q.push_back(w);
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = b;
            @(negedge clk);
            chk("byte_ready_load", {31'd0, bus.byte_ready}, 32'd1);
            chk("inf_lock_load", bus.inf_rd_data, 32'd0);
            tick();
            if (gapped && i != n - 1) begin
                bus.byte_valid = 1'b0;
                @(negedge clk);
                chk("byte_ready_gap", {31'd0, bus.byte_ready}, 32'd1);
                tick();
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    // Entered in the last write-pulse cycle; walks the verify sweep. A non-negative
    // abort_at asserts rst during that verify cycle.
    task automatic run_verify(input int abort_at);
        @(negedge clk);
        chk("byte_ready_last_pulse", {31'd0, bus.byte_ready}, 32'd0);
        chk("wr_en_last_pulse", {31'd0, bus.ram_wr_en}, 32'd1);
        tick();
        for (int j = 0; j < 10; j++) begin
            if (j == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                @(negedge clk);
                check_reset_vals("abort");
                for (int k = 0; k < 12; k++) begin
                    tick();
                    @(negedge clk);
                    chk("abort_ready", {31'd0, bus.biases_ready}, 32'd0);
                    chk("abort_rd_addr", {28'd0, bus.ram_rd_addr}, 32'd0);
                end
                return;
            end
            @(negedge clk);
            chk("verify_rd_addr", {28'd0, bus.ram_rd_addr}, 32'(j));
            chk("verify_ready", {31'd0, bus.biases_ready}, 32'd0);
            chk("inf_lock_verify", bus.inf_rd_data, 32'd0);
            tick();
        end
        @(negedge clk);
        chk("ready_after_verify", {31'd0, bus.biases_ready}, 32'd1);
    endtask

    // Monitor: pops expected writes on every RAM strobe and the checksum on ready rising.
    initial begin
        logic        prev_ready;
        logic [3:0]  a;
        logic [31:0] d;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ram_wr_en === 1'b1) begin
                if (exp_addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected",
                             bus.ram_wr_addr, bus.ram_wr_data);
                end else begin
                    a = exp_addr_q.pop_front();
                    d = exp_data_q.pop_front();
                    chk("wr_addr", {28'd0, bus.ram_wr_addr}, {28'd0, a});
                    chk("wr_data", bus.ram_wr_data, d);
                end
            end
            if (bus.biases_ready === 1'b1 && !prev_ready) begin
                if (exp_ck_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready: checksum 0x%08h, none expected",
                             bus.checksum);
                end else begin
                    chk("checksum", bus.checksum, exp_ck_q.pop_front());
                end
            end
            prev_ready = bus.biases_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.inf_rd_addr = 4'd3;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        tick();

        // Load from reset, back-to-back bytes 0x00..0x27.
        exp_ck_q.push_back(32'hD2C8BEB4);
        pulse_start();
        send_bytes(40, 8'h00, 1'b1, 1'b0);
        run_verify(-1);
        chk("ready_inf_data", bus.inf_rd_data, 32'h0F0E0D0C);
        chk("ready_rd_addr", {28'd0, bus.ram_rd_addr}, 32'd3);
        tick();

        // Stray byte while ready.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        tick();
        bus.byte_valid = 1'b0;
        @(negedge clk);
        chk("stray_load_err", {31'd0, bus.load_err}, 32'd1);
        chk("stray_ready", {31'd0, bus.biases_ready}, 32'd1);
        chk("stray_inf_data", bus.inf_rd_data, 32'h0F0E0D0C);
        tick();
        pulse_start();
        @(negedge clk);
        chk("start_clears_load_err", {31'd0, bus.load_err}, 32'd0);
        chk("start_clears_ready", {31'd0, bus.biases_ready}, 32'd0);
        chk("start_clears_checksum", bus.checksum, 32'd0);
        tick();

        // Gapped stream of the same bytes.
        exp_ck_q.push_back(32'hD2C8BEB4);
        send_bytes(40, 8'h00, 1'b1, 1'b1);
        run_verify(-1);
        chk("gapped_inf_data", bus.inf_rd_data, 32'h0F0E0D0C);
        tick();

        // Abort after 17 bytes with a byte coincident with start, then 0xFF reload.
        pulse_start();
        send_bytes(17, 8'h50, 1'b1, 1'b0);
        bus.start      = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h11;
        tick();
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        chk("abort_byte_no_err", {31'd0, bus.load_err}, 32'd0);
        chk("abort_byte_ready", {31'd0, bus.byte_ready}, 32'd1);
        tick();
        exp_ck_q.push_back(32'hFFFFFFF6);
        send_bytes(40, 8'hFF, 1'b0, 1'b0);
        run_verify(-1);
        chk("ff_inf_data", bus.inf_rd_data, 32'hFFFFFFFF);
        tick();

        // Reset in verify cycle 5.
        pulse_start();
        send_bytes(40, 8'h10, 1'b1, 1'b0);
        run_verify(5);

        repeat (3) tick();
        chk("pending_writes", 32'(exp_addr_q.size()), 32'd0);
        chk("pending_checksums", 32'(exp_ck_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
